ternary_zq_stream: RTL and testbench
====================================

// Module: ternary_zq_stream
// PURPOSE
//   Consumes the packed ternary polynomial vector produced by the ternary sampler (2 bits/coef, mod-3 form).
//   Emits it as a stream of mod-q coefficients, one per accepted beat, to the Zq multiplier input.
//   Maps trit 0->0, 1->1, 2->Q-1 (i.e. -1 mod q), and pads the stream to N_OUT coefficients with zeros.
//   Sits directly downstream of the ternary sampler in the encapsulation datapath.
// PARAMETERS
//   N_COEF  700   ternary coefficients carried in rm_in (rm_in width = 2*N_COEF)
//   N_OUT   701   coefficients emitted per frame (N_OUT >= N_COEF; indices >= N_COEF are emitted as 0)
//   Q_BITS  13    coefficient width; q = 2**Q_BITS (8192)
//   IDX_W   10    width of out_idx; must satisfy 2**IDX_W >= N_OUT
// PORTS
//   clk        in   1          single clock, rising edge
//   rst        in   1          reset, asynchronous, active-low
//   start      in   1          frame request; sampled only in IDLE
//   rm_in      in   2*N_COEF   packed trits; coef i = rm_in[2i+2:2i+1], i=0 emitted first
//   busy       out  1          high while a frame is held/streaming (state != IDLE)
//   out_valid  out  1          out_coef/out_idx/out_last valid
//   out_ready  in   1          downstream accepts current beat when out_valid & out_ready
//   out_coef   out  Q_BITS     current coefficient, mod q
//   out_idx    out  IDX_W      index of current coefficient (0..N_OUT-1)
//   out_last   out  1          high when out_idx == N_OUT-1
//   done       out  1          one-cycle pulse on the clock after the last beat is accepted
//   err_enc    out  1          sticky: a trit encoded 2'b11 was emitted this frame
// BEHAVIOUR
//   Reset (rst low, async): state=IDLE; shadow reg, out_idx=0; busy, out_valid, out_last, done, err_enc = 0;
//     out_coef = 0. Reset mid-frame aborts immediately; no partial-frame done.
//   States: IDLE, STREAM.
//   IDLE: if start=1 at edge k -> capture rm_in into 2*N_COEF shadow reg, out_idx<=0, err_enc<=0, state<=STREAM.
//     First beat valid in cycle after edge k (latency 1). start outside IDLE is ignored (no re-capture).
//   STREAM: out_valid=1 every cycle; outputs held stable while out_ready=0.
//     Beat accepted (out_valid & out_ready at edge): out_idx<=out_idx+1; shadow shifts right by 2 (zero-fill).
//     Accept with out_idx==N_OUT-1: state<=IDLE, out_valid<=0, done<=1 for exactly one cycle.
//   Coefficient map from shadow[2:1] (0 when out_idx >= N_COEF):
//     2'b00 -> 0; 2'b01 -> 1; 2'b10 -> 2**Q_BITS-1; 2'b11 -> 0 and err_enc<=1 on acceptance.
//   out_coef, out_idx, out_last, out_valid depend only on registers (no comb path from start/rm_in/out_ready).
//   out_last = out_valid & (out_idx==N_OUT-1). busy = (state==STREAM).
//   start asserted in the same cycle done pulses (state already IDLE) is accepted: back-to-back frames,
//     one idle cycle minimum between last beat of frame n and first beat of frame n+1.
//   rm_in needs to be stable only at the capturing edge; the sampler may refill its SIPO during STREAM.
//   err_enc holds until the next accepted start or reset.
//   Throughput: 1 coef/cycle with out_ready tied high; frame = N_OUT cycles + 1 capture cycle.
// TESTING
//   1. Reset: rst low mid-sim -> busy=0,out_valid=0,done=0,err_enc=0,out_coef=0 asynchronously, no clock needed.
//   2. rm_in coefs {0,1,2,1,0...} (rm_in[8:1]=8'b01_10_01_00), start, out_ready=1 -> out_coef 0,1,8191,1,0...;
//      out_idx 0..700; out_last only on idx 700 (coef 0); done 1 cycle after; 701 beats total.
//   3. Backpressure: out_ready toggled pseudo-randomly -> identical coef sequence as test 2, outputs stable
//      while stalled, no beat dropped or duplicated.
//   4. All coefs=2 -> beats 0..699 = 8191, beat 700 = 0; start pulsed during STREAM ignored (idx not reset).
//   5. Coef 5 = 2'b11 -> beat 5 = 0, err_enc rises after that acceptance, stays 1, clears on next start.
//   6. Reset at out_idx=350 -> IDLE, no done; then new start streams fresh frame from idx 0 with new rm_in.

Source files
------------

// File: rtl/ternary_zq_stream_if.sv
// Coefficient stream from the ternary-to-Zq converter into the Zq multiplier.
// Valid/ready handshake carrying the coefficient, its index and a last-beat flag.
interface ternary_zq_stream_if #(
   parameter int Q_BITS = 13,
   parameter int IDX_W  = 10
);
   logic              out_valid;
   logic              out_ready;
   logic [Q_BITS-1:0] out_coef;
   logic [IDX_W-1:0]  out_idx;
   logic              out_last;

   modport master (
      output out_valid,
      output out_coef,
      output out_idx,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_coef,
      input  out_idx,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/ternary_zq_stream.sv
// Converts a captured packed trit vector (2 bits/coef, mod-3 form) into a stream of mod-q
// coefficients, zero-padded to N_OUT beats per frame.
module ternary_zq_stream #(
   parameter int N_COEF = 700,
   parameter int N_OUT  = 701,
   parameter int Q_BITS = 13,
   parameter int IDX_W  = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [2*N_COEF:1]   rm_in,
   output logic                busy,
   output logic                done,
   output logic                err_enc,
   ternary_zq_stream_if.master zq
);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t             state_q, state_d;
   logic [2*N_COEF:1]  shadow_q;
   logic [IDX_W-1:0]   idx_q;
   logic               valid;
   logic               accept;
   logic               at_last;
   logic               in_range;
   logic               capture;

   // Trit to mod-q: 2 is -1 mod q; the illegal code 3 maps to 0 and is flagged separately.
   function automatic logic [Q_BITS-1:0] map_trit(input logic [1:0] t);
      case (t)
         2'b01:   map_trit = Q_BITS'(1);
         2'b10:   map_trit = '1;
         default: map_trit = '0;
      endcase
   endfunction

   assign valid    = (state_q == STREAM);
   assign accept   = valid & zq.out_ready;
   assign at_last  = (idx_q == IDX_W'(N_OUT - 1));
   assign in_range = (idx_q < IDX_W'(N_COEF));

   assign busy         = valid;
   assign zq.out_valid = valid;
   assign zq.out_idx   = idx_q;
   assign zq.out_last  = valid & at_last;
   assign zq.out_coef  = (valid && in_range) ? map_trit(shadow_q[2:1]) : '0;

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               capture = 1'b1;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (accept && at_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Shadow copy frees the sampler to refill rm_in while this frame streams out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow_q <= '0;
         idx_q    <= '0;
         done     <= 1'b0;
         err_enc  <= 1'b0;
      end else begin
         done <= accept & at_last;
         if (capture) begin
            shadow_q <= rm_in;
            idx_q    <= '0;
            err_enc  <= 1'b0;
         end else if (accept) begin
            shadow_q <= {2'b00, shadow_q[2*N_COEF:3]};
            idx_q    <= at_last ? '0 : idx_q + IDX_W'(1);
            if (in_range && shadow_q[2:1] == 2'b11) err_enc <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ternary_zq_stream.sv
// Directed bench for ternary_zq_stream: reset, plain and backpressured frames, padding,
// ignored restart, illegal-code flag and mid-frame reset.
module tb_ternary_zq_stream;
   localparam int N_COEF = 700;
   localparam int N_OUT  = 701;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [2*N_COEF:1] rm_in;
   logic              busy;
   logic              done;
   logic              err_enc;

   int checks   = 0;
   int failures = 0;

   logic [12:0] expv [0:N_OUT-1];

   ternary_zq_stream_if #(.Q_BITS(13), .IDX_W(10)) zq ();

   ternary_zq_stream #(.N_COEF(N_COEF), .N_OUT(N_OUT), .Q_BITS(13), .IDX_W(10)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .rm_in   (rm_in),
      .busy    (busy),
      .done    (done),
      .err_enc (err_enc),
      .zq      (zq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; first beat must be presented on the following cycle.
   task automatic do_start(input string tag);
      start = 1'b1;
      zq.out_ready = 1'b0;
      tick();
      start = 1'b0;
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_valid"}, zq.out_valid, 1);
      chk({tag, "_idx0"}, zq.out_idx, 0);
      chk({tag, "_done_low"}, done, 0);
   endtask

   // Accepts beats from..to-1, checking each accepted beat and stability across stalls.
   task automatic run_frame(input string tag, input bit bp, input int from, input int to);
      int          beats;
      int          cyc;
      bit          stalled;
      bit          r;
      logic [12:0] pc;
      logic [9:0]  pi;
      beats   = from;
      cyc     = 0;
      stalled = 1'b0;
      pc      = '0;
      pi      = '0;
      while (beats < to && cyc < 5000) begin
         if (stalled) begin
            chk({tag, "_stall_coef"}, zq.out_coef, pc);
            chk({tag, "_stall_idx"}, zq.out_idx, pi);
         end
         r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         zq.out_ready = r;
         if (r) begin
            chk({tag, "_valid"}, zq.out_valid, 1);
            chk({tag, "_coef"}, zq.out_coef, expv[beats]);
            chk({tag, "_idx"}, zq.out_idx, beats);
            chk({tag, "_last"}, zq.out_last, (beats == N_OUT - 1));
            beats++;
         end
         stalled = !r;
         pc = zq.out_coef;
         pi = zq.out_idx;
         tick();
         cyc++;
      end
      zq.out_ready = 1'b0;
      if (cyc >= 5000) chk({tag, "_timeout_beats"}, beats, to);
   endtask

   task automatic end_checks(input string tag);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_end_valid"}, zq.out_valid, 0);
      chk({tag, "_end_busy"}, busy, 0);
      chk({tag, "_end_idx"}, zq.out_idx, 0);
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      rm_in = '0;
      zq.out_ready = 1'b0;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_valid", zq.out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err_enc, 0);
      chk("rst_coef", zq.out_coef, 0);
      tick();
      rst = 1'b1;
      tick();

      // Coefs {0,1,2,1,0,...}
      rm_in[8:1] = 8'b01_10_01_00;
      for (int i = 0; i < N_OUT; i++) expv[i] = 13'd0;
      expv[1] = 13'd1;
      expv[2] = 13'd8191;
      expv[3] = 13'd1;
      do_start("t2");
      run_frame("t2", 1'b0, 0, N_OUT);
      end_checks("t2");

      // Back-to-back: start during the done pulse, with backpressure.
      do_start("t3");
      run_frame("t3", 1'b1, 0, N_OUT);
      end_checks("t3");
      tick();
      chk("t3_done_pulse_one_cycle", done, 0);

      // All coefs = 2; restart and rm_in changes during STREAM must be ignored.
      for (int i = 0; i < N_COEF; i++) rm_in[2*i+2 -: 2] = 2'b10;
      for (int i = 0; i < N_COEF; i++) expv[i] = 13'd8191;
      expv[N_OUT-1] = 13'd0;
      do_start("t4");
      rm_in = '0;
      run_frame("t4", 1'b0, 0, 10);
      start = 1'b1;
      zq.out_ready = 1'b1;
      tick();
      start = 1'b0;
      chk("t4_restart_ignored_idx", zq.out_idx, 11);
      chk("t4_restart_ignored_coef", zq.out_coef, 8191);
      run_frame("t4", 1'b0, 11, N_OUT);
      end_checks("t4");
      tick();

      // Coef 5 encoded 2'b11.
      rm_in = '0;
      rm_in[12:11] = 2'b11;
      for (int i = 0; i < N_OUT; i++) expv[i] = 13'd0;
      do_start("t5");
      chk("t5_err_start", err_enc, 0);
      run_frame("t5", 1'b0, 0, 5);
      chk("t5_err_before", err_enc, 0);
      run_frame("t5", 1'b0, 5, 6);
      chk("t5_err_after", err_enc, 1);
      run_frame("t5", 1'b0, 6, N_OUT);
      end_checks("t5");
      chk("t5_err_sticky", err_enc, 1);
      tick();
      chk("t5_err_idle", err_enc, 1);

      // New frame clears err; reset at idx 350 aborts it.
      rm_in = '0;
      rm_in[8:1] = 8'b01_10_01_00;
      expv[1] = 13'd1;
      expv[2] = 13'd8191;
      expv[3] = 13'd1;
      do_start("t6");
      chk("t5_err_cleared", err_enc, 0);
      run_frame("t6", 1'b0, 0, 350);
      chk("t6_idx350", zq.out_idx, 350);
      #2;
      rst = 1'b0;
      #1;
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_valid", zq.out_valid, 0);
      chk("t6_rst_done", done, 0);
      chk("t6_rst_err", err_enc, 0);
      chk("t6_rst_coef", zq.out_coef, 0);
      chk("t6_rst_idx", zq.out_idx, 0);
      tick();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t6_no_done", done, 0);
         chk("t6_idle_busy", busy, 0);
      end

      // Fresh frame, all coefs = 1.
      for (int i = 0; i < N_COEF; i++) rm_in[2*i+2 -: 2] = 2'b01;
      for (int i = 0; i < N_COEF; i++) expv[i] = 13'd1;
      expv[N_OUT-1] = 13'd0;
      do_start("t6b");
      run_frame("t6b", 1'b1, 0, N_OUT);
      end_checks("t6b");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
